// File: rtl/sweep_pkg.sv
// Package: sweep_pkg
// Shared types and defaults for the counter sweep controller.
//   sweep_state_e : FSM state encoding (dwell states exist only when the
//                   SWEEP_DWELL_EN macro is defined)
//   WIDTH_DEF     : counter data width
//   CW_DEF        : sweep-count request width
//   STALL_LIMIT_DEF : consecutive no-change cycles that flag a stall
//   DWELL_CYCLES  : hold cycles at each extreme (SWEEP_DWELL_EN builds only)
//   CNT_MAX       : counter full-scale value, 2^WIDTH-1
package sweep_pkg;

  localparam int WIDTH_DEF       = 5;
  localparam int CW_DEF          = 4;
  localparam int STALL_LIMIT_DEF = 4;
  localparam int DWELL_CYCLES    = 3;

  localparam logic [WIDTH_DEF-1:0] CNT_MAX = {WIDTH_DEF{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RISE,
    ST_FALL,
    ST_DONE
`ifdef SWEEP_DWELL_EN
    ,
    ST_DWELL_HI,
    ST_DWELL_LO
`endif
  } sweep_state_e;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Interface: counter_sweep_ctrl_if
// Command/status bundle between the sweep controller and a 5-bit up/down
// counter.
//   IN      : load value (controller -> counter)
//   Load    : load strobe (controller -> counter)
//   Up      : count-up request (controller -> counter)
//   Down    : count-down request (controller -> counter)
//   High    : counter is at full scale (counter -> controller)
//   Low     : counter is at zero (counter -> controller)
//   Counter : current counter value (counter -> controller)
// Protocol: Load, Up and Down are level requests, at most one of them high in
// any cycle; the counter acts on them at the rising clock edge that ends the
// cycle (Load wins, Up stops at full scale, Down stops at zero). High, Low and
// Counter always describe the value held during the current cycle.
interface counter_sweep_ctrl_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] IN;
  logic             Load;
  logic             Up;
  logic             Down;
  logic             High;
  logic             Low;
  logic [WIDTH-1:0] Counter;

  modport master (
    output IN, Load, Up, Down,
    input  High, Low, Counter
  );

  modport slave (
    input  IN, Load, Up, Down,
    output High, Low, Counter
  );
endinterface

// File: rtl/sweep_stall_mon.sv
// Module: sweep_stall_mon
// Watches the counter value while a count request is active and raises a
// one-cycle stall pulse on the STALL_LIMIT-th consecutive requested cycle in
// which the value did not change from the previous cycle.
//   CLK     in  clock
//   RST_n   in  synchronous active-low reset
//   active  in  Up or Down currently requested
//   counter in  counter value
//   stall   out stall detected this cycle (combinational)
module sweep_stall_mon #(
  parameter int WIDTH       = 5,
  parameter int STALL_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             active,
  input  logic [WIDTH-1:0] counter,
  output logic             stall
);
  localparam int SCW = $clog2(STALL_LIMIT + 1);

  logic [WIDTH-1:0] prev_q;
  logic [SCW-1:0]   stall_cnt;
  logic             hit;

  assign hit   = active && (counter == prev_q);
  // Fires on the cycle that would bring stall_cnt up to STALL_LIMIT, so the
  // controller can leave on that same edge.
  assign stall = hit && (stall_cnt == SCW'(STALL_LIMIT - 1));

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      prev_q    <= '0;
      stall_cnt <= '0;
    end else begin
      prev_q <= counter;
      if (!hit)
        stall_cnt <= '0;
      else if (stall_cnt != SCW'(STALL_LIMIT))
        stall_cnt <= stall_cnt + SCW'(1);
    end
  end
endmodule

// File: rtl/counter_sweep_ctrl.sv
// Module: counter_sweep_ctrl
// Command-side master for an up/down counter: loads a start value, then runs
// the requested number of up-to-High / down-to-Low sweeps, pulses Done on
// completion and raises a sticky Err if the counter stops responding.
// Optional feature macro: SWEEP_DWELL_EN adds DWELL_CYCLES idle cycles at each
// extreme before the sweep continues.
// Ports:
//   CLK        in   clock, all logic on posedge
//   RST_n      in   synchronous active-low reset
//   Start      in   begin operation (sampled only in IDLE)
//   Abort      in   return to IDLE on next edge, no Done
//   Start_Val  in   value loaded into the counter
//   Sweeps     in   number of up+down sweeps (0 = load only)
//   ctr        if   counter bus (master side): IN/Load/Up/Down out,
//                   High/Low/Counter in
//   Busy       out  high in every state except IDLE
//   Done       out  one-cycle completion pulse
//   Err        out  sticky stall flag, cleared by the next accepted Start
//   dbg_state  out  current FSM state
module counter_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int CW          = CW_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic [WIDTH-1:0]       Start_Val,
  input  logic [CW-1:0]          Sweeps,
  counter_sweep_ctrl_if.master   ctr,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Err,
  output sweep_state_e           dbg_state
);

  sweep_state_e     state, state_nxt;
  logic [WIDTH-1:0] in_q;
  logic [CW-1:0]    sw_q;
  logic [CW-1:0]    sweep_cnt;
  logic             err_q, load_q, busy_q, done_q;
  logic             accept, stall, sweep_step, last_sweep;

`ifdef SWEEP_DWELL_EN
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  logic [DW-1:0] dwell_cnt;
  logic          dwell_end;
  assign dwell_end = (dwell_cnt == DW'(DWELL_CYCLES - 1));
`endif

  // Up/Down follow High/Low in the same cycle so the counter never gets a
  // request past its end stop.
  assign ctr.Up   = (state == ST_RISE) && !ctr.High;
  assign ctr.Down = (state == ST_FALL) && !ctr.Low;
  assign ctr.Load = load_q;
  assign ctr.IN   = in_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign dbg_state = state;

  assign accept     = (state == ST_IDLE) && Start && !Abort;
  // Compared before the increment, so Sweeps at full scale ends without wrap.
  assign last_sweep = ((sweep_cnt + CW'(1)) == sw_q);
  assign sweep_step = (state == ST_FALL) && ctr.Low && !Abort;

  sweep_stall_mon #(
    .WIDTH       (WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_mon (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .active  (ctr.Up || ctr.Down),
    .counter (ctr.Counter),
    .stall   (stall)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = (sw_q == '0) ? ST_DONE : ST_RISE;
      ST_RISE: begin
        if (ctr.High) begin
`ifdef SWEEP_DWELL_EN
          state_nxt = ST_DWELL_HI;
`else
          state_nxt = ST_FALL;
`endif
        end
      end
      ST_FALL: begin
        if (ctr.Low) begin
`ifdef SWEEP_DWELL_EN
          state_nxt = ST_DWELL_LO;
`else
          state_nxt = last_sweep ? ST_DONE : ST_RISE;
`endif
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
`ifdef SWEEP_DWELL_EN
      ST_DWELL_HI: if (dwell_end) state_nxt = ST_FALL;
      // sweep_cnt was already advanced on the way out of FALL.
      ST_DWELL_LO: if (dwell_end) state_nxt = (sweep_cnt == sw_q) ? ST_DONE : ST_RISE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
    if (stall) state_nxt = ST_IDLE;
    if (Abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state     <= ST_IDLE;
      in_q      <= '0;
      sw_q      <= '0;
      sweep_cnt <= '0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      load_q <= (state_nxt == ST_LOAD);
      busy_q <= (state_nxt != ST_IDLE);
      done_q <= (state_nxt == ST_DONE);
      if (accept) begin
        in_q      <= Start_Val;
        sw_q      <= Sweeps;
        sweep_cnt <= '0;
        err_q     <= 1'b0;
      end else begin
        if (state_nxt == ST_IDLE) in_q <= '0;
        if (sweep_step) sweep_cnt <= sweep_cnt + CW'(1);
        if (stall && !Abort) err_q <= 1'b1;
      end
    end
  end

`ifdef SWEEP_DWELL_EN
  always_ff @(posedge CLK) begin
    if (!RST_n)
      dwell_cnt <= '0;
    else if ((state == ST_DWELL_HI || state == ST_DWELL_LO) && state_nxt == state)
      dwell_cnt <= dwell_cnt + DW'(1);
    else
      dwell_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;
  import sweep_pkg::*;

  localparam int MAXV = 31;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST_n;
  logic         Start, Abort;
  logic [4:0]   Start_Val;
  logic [3:0]   Sweeps;
  logic         Busy, Done, Err;
  sweep_state_e dbg_state;
  logic         freeze_down;
  logic [4:0]   cnt_m;

  int total = 0;
  int bad   = 0;

  counter_sweep_ctrl_if #(.WIDTH(5)) bus ();

  counter_sweep_ctrl dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .Start     (Start),
    .Abort     (Abort),
    .Start_Val (Start_Val),
    .Sweeps    (Sweeps),
    .ctr       (bus),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .dbg_state (dbg_state)
  );

  // behavioural up/down counter the controller drives
  always @(posedge CLK) begin
    if (!RST_n)                             cnt_m <= 5'd0;
    else if (bus.Load)                      cnt_m <= bus.IN;
    else if (bus.Up && cnt_m != 5'd31)      cnt_m <= cnt_m + 5'd1;
    else if (bus.Down && !freeze_down && cnt_m != 5'd0) cnt_m <= cnt_m - 5'd1;
  end
  assign bus.Counter = cnt_m;
  assign bus.High    = (cnt_m == 5'd31);
  assign bus.Low     = (cnt_m == 5'd0);

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction; expectations come from the sweep arithmetic:
  // first rise needs 31-sv Up pulses, every later rise 31, every fall 31;
  // each leg spends one extra cycle seeing the end stop.
  task automatic run_txn(input logic [4:0] sv, input logic [3:0] sw, input bit poke);
    int exp_up, exp_down, exp_lat, budget;
    int n_load, n_up, n_down, n_done, excl_bad, busy_gap, done_cyc;
    logic [4:0] load_in;
    logic err_at_load;
    exp_up   = (sw == 0) ? 0 : (MAXV - int'(sv)) + (int'(sw) - 1) * MAXV;
    exp_down = int'(sw) * MAXV;
    exp_lat  = (sw == 0) ? 2 : 1 + (32 - int'(sv)) + 32 + (int'(sw) - 1) * 64 + 1;
    budget   = exp_lat + 40;
    n_load = 0; n_up = 0; n_down = 0; n_done = 0; excl_bad = 0; busy_gap = 0;
    done_cyc = 0; load_in = '0; err_at_load = 1'b1;

    @(negedge CLK);
    Start_Val = sv; Sweeps = sw; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (poke && cyc == 10) begin Start = 1'b1; Start_Val = ~sv; Sweeps = 4'd0; end
      if (poke && cyc == 11) Start = 1'b0;
      if (cyc == 1) err_at_load = Err;
      if (int'(bus.Load) + int'(bus.Up) + int'(bus.Down) > 1) excl_bad++;
      if (!Busy) busy_gap++;
      if (bus.Load) begin n_load++; load_in = bus.IN; end
      if (bus.Up)   n_up++;
      if (bus.Down) n_down++;
      if (Done) begin n_done++; done_cyc = cyc; break; end
    end
    Start = 1'b0;
    check($sformatf("done_seen sv=%0d sw=%0d", sv, sw), n_done, 1);
    check("done_latency", done_cyc, exp_lat);
    check("load_cycles", n_load, 1);
    check("load_value", {27'd0, load_in}, {27'd0, sv});
    check("up_pulses", n_up, exp_up);
    check("down_pulses", n_down, exp_down);
    check("req_exclusive", excl_bad, 0);
    check("busy_held", busy_gap, 0);
    check("err_cleared", {31'd0, err_at_load}, 0);
    @(negedge CLK);
    check("post_done", {31'd0, Done}, 0);
    check("post_busy", {31'd0, Busy}, 0);
    check("final_count", {27'd0, cnt_m}, (sw == 0) ? {27'd0, sv} : 32'd0);
    check("final_err", {31'd0, Err}, 0);
  endtask

  initial begin
    int n, found;
    RST_n = 1'b0; Start = 1'b0; Abort = 1'b0; Start_Val = '0; Sweeps = '0;
    freeze_down = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outs", {21'd0, bus.IN, bus.Load, bus.Up, bus.Down, Busy, Done, Err}, 0);
    check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    RST_n = 1'b1;

    // directed sweeps and boundaries
    run_txn(5'd28, 4'd1, 1'b0);
    run_txn(5'd31, 4'd2, 1'b0);
    run_txn(5'd9,  4'd0, 1'b0);
    run_txn(5'd0,  4'd1, 1'b1);
    run_txn(5'($urandom_range(0, 31)), 4'd15, 1'b0);

    // random sweeps
    for (int i = 0; i < 6; i++)
      run_txn(5'($urandom_range(0, 31)), 4'($urandom_range(0, 3)), i[0]);

    // frozen counter on the way down -> stall error
    freeze_down = 1'b1;
    @(negedge CLK);
    Start_Val = 5'd20; Sweeps = 4'd1; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    found = 0; n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Down) n++;
      if (Done) found = 2;
      if (Err && !Busy) begin found = found + 1; break; end
      @(negedge CLK);
    end
    check("stall_err", found, 1);
    check("stall_down_cycles", n, STALL_LIMIT_DEF);
    freeze_down = 1'b0;
    run_txn(5'd3, 4'd1, 1'b0);

    // abort mid-rise at Counter=17
    @(negedge CLK);
    Start_Val = 5'd10; Sweeps = 4'd1; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.Up && cnt_m == 5'd17) begin found = 1; break; end
      @(negedge CLK);
    end
    check("abort_reach17", found, 1);
    Abort = 1'b1;
    @(negedge CLK);
    Abort = 1'b0;
    check("abort_busy", {31'd0, Busy}, 0);
    check("abort_up", {31'd0, bus.Up}, 0);
    check("abort_err", {31'd0, Err}, 0);
    n = 0;
    repeat (40) begin
      if (Done || Busy) n++;
      @(negedge CLK);
    end
    check("abort_quiet", n, 0);

    // reset during fall
    Start_Val = 5'd5; Sweeps = 4'd2; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Down) begin found = 1; break; end
      @(negedge CLK);
    end
    check("reset_reach_fall", found, 1);
    RST_n = 1'b0;
    @(negedge CLK);
    check("midrun_reset_outs", {21'd0, bus.IN, bus.Load, bus.Up, bus.Down, Busy, Done, Err}, 0);
    check("midrun_reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    RST_n = 1'b1;
    run_txn(5'd7, 4'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
